// File: rtl/mcs6530_pkg.sv
// Shared types and helpers for the mcs6530 processor-side bus sequencer.
//   bus_req_t : one bus access as seen on the device pins (direction, RS0, address, write data)
//   BUS_IDLE  : pin values while no access is in progress (decodes as a read of address 0)
//   state_e   : sequencer state (device held in reset / bus idle / access in progress)
//   read_result() : value returned to a requester when its access completes
package mcs6530_pkg;

  typedef struct packed {
    logic       we;
    logic       rs0;
    logic [9:0] addr;
    logic [7:0] wdata;
  } bus_req_t;

  localparam bus_req_t BUS_IDLE = '{we: 1'b0, rs0: 1'b0, addr: 10'h000, wdata: 8'h00};

  typedef enum logic [1:0] {
    RESET = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2
  } state_e;

  // Writes return 0; reads return the device data when it drives the bus,
  // otherwise the floating-bus value.
  function automatic logic [7:0] read_result(input logic       we,
                                             input logic       oe,
                                             input logic [7:0] dout,
                                             input logic [7:0] open_bus);
    logic [7:0] res;
    if (we) begin
      res = 8'h00;
    end else if (oe) begin
      res = dout;
    end else begin
      res = open_bus;
    end
    return res;
  endfunction

endpackage

// File: rtl/mcs6530_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request after position ptr
// (wrapping), so the most recently served requester has lowest priority.
//   req    in  NREQ  request vector
//   ptr    in  PW    index of the last winner
//   en     in  1     arbitration allowed this clk; grant is 0 when low
//   grant  out NREQ  one-hot grant (or 0)
//   winner out PW    index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner
);

  logic          found_s;
  logic [PW-1:0] idx_s;
  int            pos_s;

  // Walk ptr+1 .. ptr+NREQ (mod NREQ) and take the first active request.
  always_comb begin
    grant   = '0;
    winner  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    pos_s   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos_s = (int'(ptr) + i) % NREQ;
      idx_s = pos_s[PW-1:0];
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        winner       = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mcs6530_bus_sequencer.sv
// Bus master sharing the mcs6530 processor-side bus between NREQ requesters.
// Generates a free-running phi2, holds the device in reset for RST_PHI2 phi2
// periods after rst, then grants at most one access per phi2 period
// (round robin). An access is granted at the last clk of a phi2 period, is
// driven for the whole following period, and completes at its last clk.
//   clk, rst                     system clock, synchronous active-high reset
//   req_valid/we/rs0/addr/wdata  per-requester request fields (slices of 10/8 bits)
//   req_ready                    combinational one-hot accept pulse
//   rsp_valid, rsp_rdata         one-clk completion pulse and read data
//   dev_*                        mcs6530 pins (phi2, RES, CS1, RS0, R_W, A, DI / DO, OE)
module mcs6530_bus_sequencer
  import mcs6530_pkg::*;
#(
  parameter int         NREQ     = 2,
  parameter int         PHI_DIV  = 2,
  parameter int         RST_PHI2 = 4,
  parameter logic [7:0] OPEN_BUS = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ-1:0]    req_rs0,
  input  logic [NREQ*10-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               dev_phi2,
  output logic               dev_res_n,
  output logic               dev_cs1,
  output logic               dev_rs0,
  output logic               dev_r_w,
  output logic [9:0]         dev_addr,
  output logic [7:0]         dev_data_i,
  input  logic [7:0]         dev_data_o,
  input  logic               dev_oe
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PHW = $clog2(2 * PHI_DIV);
  localparam int RCW = (RST_PHI2 > 0) ? $clog2(RST_PHI2 + 1) : 1;
  localparam logic [PHW-1:0] PH_LAST  = PHW'(2 * PHI_DIV - 1);
  localparam logic [PHW-1:0] PH_HIGH  = PHW'(PHI_DIV);
  localparam logic [RCW-1:0] RST_LAST = RCW'((RST_PHI2 > 0) ? RST_PHI2 - 1 : 0);

  logic [PHW-1:0]  ph_r;
  logic            dev_phi2_r;
  logic            dev_res_n_r;
  logic [RCW-1:0]  rst_cnt_r;
  state_e          state_r;
  bus_req_t        bus_r;
  logic            cs1_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   owner_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [7:0]      rsp_rdata_r;

  logic [PHW-1:0]  ph_nxt_s;
  logic            cyc_end_s;
  logic            arb_en_s;
  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   winner_s;
  bus_req_t        req_sel_s;
  state_e          state_nxt_s;
  logic [RCW-1:0]  rst_cnt_nxt_s;
  logic            complete_s;
  logic [NREQ-1:0] rsp_valid_nxt_s;

  // Grants only on the period boundary and never while the device is in
  // reset; rst also masks the combinational ready so nothing is accepted
  // on the edge that discards state.
  assign arb_en_s = cyc_end_s && (state_r != RESET) && !rst;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_r),
    .en     (arb_en_s),
    .grant  (grant_s),
    .winner (winner_s)
  );

  // Phase counter next value and end-of-period strobe.
  always_comb begin
    cyc_end_s = (ph_r == PH_LAST);
    if (cyc_end_s) begin
      ph_nxt_s = '0;
    end else begin
      ph_nxt_s = ph_r + PHW'(1);
    end
  end

  // Extract the winning requester's fields into a bus access.
  always_comb begin
    req_sel_s       = BUS_IDLE;
    req_sel_s.we    = req_we[winner_s];
    req_sel_s.rs0   = req_rs0[winner_s];
    req_sel_s.addr  = req_addr[10*int'(winner_s) +: 10];
    req_sel_s.wdata = req_wdata[8*int'(winner_s) +: 8];
  end

  // Next state, reset-period counter and completion pulse.
  always_comb begin
    state_nxt_s     = state_r;
    rst_cnt_nxt_s   = rst_cnt_r;
    complete_s      = (state_r == BUSY) && cyc_end_s;
    rsp_valid_nxt_s = '0;
    case (state_r)
      RESET: begin
        if (cyc_end_s) begin
          if (rst_cnt_r == RST_LAST) begin
            state_nxt_s = IDLE;
          end else begin
            rst_cnt_nxt_s = rst_cnt_r + RCW'(1);
          end
        end else begin
          state_nxt_s = RESET;
        end
      end
      IDLE, BUSY: begin
        if (cyc_end_s) begin
          if (|grant_s) begin
            state_nxt_s = BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = RESET;
      end
    endcase
    if (complete_s) begin
      rsp_valid_nxt_s[owner_r] = 1'b1;
    end else begin
      rsp_valid_nxt_s = '0;
    end
  end

  // State, clock generation, bus pin and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r        <= '0;
      dev_phi2_r  <= 1'b0;
      dev_res_n_r <= 1'b0;
      rst_cnt_r   <= '0;
      state_r     <= RESET;
      bus_r       <= BUS_IDLE;
      cs1_r       <= 1'b0;
      ptr_r       <= PW'(NREQ - 1);
      owner_r     <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= 8'h00;
    end else begin
      ph_r        <= ph_nxt_s;
      dev_phi2_r  <= (ph_nxt_s >= PH_HIGH);
      dev_res_n_r <= (state_nxt_s != RESET);
      rst_cnt_r   <= rst_cnt_nxt_s;
      state_r     <= state_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      if (complete_s) begin
        rsp_rdata_r <= read_result(bus_r.we, dev_oe, dev_data_o, OPEN_BUS);
      end
      // A new access replaces the completing one on the same edge, so
      // back-to-back accesses keep CS1 high with no idle period.
      if (arb_en_s) begin
        if (|grant_s) begin
          bus_r   <= req_sel_s;
          cs1_r   <= 1'b1;
          ptr_r   <= winner_s;
          owner_r <= winner_s;
        end else begin
          bus_r   <= BUS_IDLE;
          cs1_r   <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign dev_phi2   = dev_phi2_r;
  assign dev_res_n  = dev_res_n_r;
  assign dev_cs1    = cs1_r;
  assign dev_rs0    = bus_r.rs0;
  assign dev_r_w    = ~bus_r.we;
  assign dev_addr   = bus_r.addr;
  assign dev_data_i = bus_r.wdata;

endmodule

// File: tb/tb_mcs6530_bus_sequencer.sv
// Self-checking bench for mcs6530_bus_sequencer. A timeline model counts clk
// edges since reset release and derives phi2, RES, grant slots and access
// windows from plain arithmetic; requests are held in per-requester arrays.
module tb_mcs6530_bus_sequencer;

  localparam int         NREQ     = 2;
  localparam int         PHI_DIV  = 2;
  localparam int         RST_PHI2 = 4;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam int         PER      = 2 * PHI_DIV;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_rs0;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*8-1:0]  req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [7:0]         rsp_rdata;
  logic               dev_phi2;
  logic               dev_res_n;
  logic               dev_cs1;
  logic               dev_rs0;
  logic               dev_r_w;
  logic [9:0]         dev_addr;
  logic [7:0]         dev_data_i;
  logic [7:0]         dev_data_o;
  logic               dev_oe;

  mcs6530_bus_sequencer #(
    .NREQ(NREQ), .PHI_DIV(PHI_DIV), .RST_PHI2(RST_PHI2), .OPEN_BUS(OPEN_BUS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_rs0(req_rs0),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dev_phi2(dev_phi2), .dev_res_n(dev_res_n), .dev_cs1(dev_cs1), .dev_rs0(dev_rs0),
    .dev_r_w(dev_r_w), .dev_addr(dev_addr), .dev_data_i(dev_data_i),
    .dev_data_o(dev_data_o), .dev_oe(dev_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // timeline model
  int         k;
  int         ptr_m;
  bit         act_m;
  int         own_m;
  bit         a_we;
  bit         a_rs0;
  logic [9:0] a_addr;
  logic [7:0] a_wd;
  logic [7:0] a_dout;
  bit         a_oe;
  logic [NREQ-1:0] exp_rsp;
  logic [7:0]      exp_rdata;

  // pending requests
  bit         p_v   [NREQ];
  bit         p_we  [NREQ];
  bit         p_rs0 [NREQ];
  logic [9:0] p_addr[NREQ];
  logic [7:0] p_wd  [NREQ];

  bit         use_force;
  logic [7:0] f_dout;
  bit         f_oe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= NREQ; i++) begin
      int j;
      j = (ptr_m + i) % NREQ;
      if (p_v[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = p_v[i];
      req_we[i]            = p_we[i];
      req_rs0[i]           = p_rs0[i];
      req_addr[10*i +: 10] = p_addr[i];
      req_wdata[8*i +: 8]  = p_wd[i];
    end
    dev_data_o = a_dout;
    dev_oe     = a_oe;
  endtask

  task automatic gen(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!p_v[i] && ($urandom_range(99) < pct)) begin
        p_v[i]    = 1'b1;
        p_we[i]   = 1'($urandom_range(1));
        p_rs0[i]  = 1'($urandom_range(1));
        p_addr[i] = 10'($urandom_range(1023));
        p_wd[i]   = 8'($urandom_range(255));
      end
    end
  endtask

  task automatic model_reset();
    k       = 0;
    ptr_m   = NREQ - 1;
    act_m   = 1'b0;
    exp_rsp = '0;
  endtask

  // One clk: drive at negedge, check 1 time unit later, step the model
  // across the coming posedge, then move to the next negedge.
  task automatic one_cycle(input bit do_rst);
    int              w;
    bit              slot;
    logic [NREQ-1:0] er;
    rst = do_rst;
    drive_inputs();
    #1;
    slot = ((k % PER) == PER - 1);
    chk("phi2", 32'(dev_phi2), 32'((k % PER) >= PHI_DIV));
    chk("res_n", 32'(dev_res_n), 32'(k >= PER * RST_PHI2));
    w = -1;
    if (!do_rst && slot && (k >= PER * (RST_PHI2 + 1) - 1)) w = rr_pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("cs1", 32'(dev_cs1), 32'(act_m));
    chk("r_w", 32'(dev_r_w), act_m ? 32'(!a_we) : 32'd1);
    chk("rs0", 32'(dev_rs0), act_m ? 32'(a_rs0) : 32'd0);
    chk("addr", 32'(dev_addr), act_m ? 32'(a_addr) : 32'd0);
    chk("data_i", 32'(dev_data_i), act_m ? 32'(a_wd) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    if (do_rst) begin
      model_reset();
    end else begin
      exp_rsp = '0;
      if (slot && act_m) begin
        exp_rsp[own_m] = 1'b1;
        exp_rdata      = a_we ? 8'h00 : (a_oe ? a_dout : OPEN_BUS);
        act_m          = 1'b0;
      end
      if (w >= 0) begin
        act_m  = 1'b1;
        own_m  = w;
        ptr_m  = w;
        a_we   = p_we[w];
        a_rs0  = p_rs0[w];
        a_addr = p_addr[w];
        a_wd   = p_wd[w];
        p_v[w] = 1'b0;
        if (use_force) begin
          a_dout = f_dout;
          a_oe   = f_oe;
        end else begin
          a_dout = 8'($urandom_range(255));
          a_oe   = 1'($urandom_range(1));
        end
      end
      k++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit we, input bit rs0,
                         input logic [9:0] addr, input logic [7:0] wd);
    p_v[i]    = 1'b1;
    p_we[i]   = we;
    p_rs0[i]  = rs0;
    p_addr[i] = addr;
    p_wd[i]   = wd;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin
      p_v[i] = 1'b0; p_we[i] = 1'b0; p_rs0[i] = 1'b0; p_addr[i] = 10'h000; p_wd[i] = 8'h00;
    end
    a_dout = 8'h00; a_oe = 1'b0; a_we = 1'b0; a_rs0 = 1'b0; a_addr = 10'h000; a_wd = 8'h00;
    own_m = 0; exp_rdata = 8'h00; use_force = 1'b0; f_dout = 8'h00; f_oe = 1'b0;
    rst = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cs1", 32'(dev_cs1), 32'd0);
    chk("rst_res_n", 32'(dev_res_n), 32'd0);
    model_reset();

    // reset for 3 clk, then idle through the device reset period
    repeat (3) one_cycle(1'b1);
    repeat (22) one_cycle(1'b0);

    // requester 0 write
    set_req(0, 1'b1, 1'b0, 10'h301, 8'hA5);
    repeat (12) one_cycle(1'b0);

    // requester 1 read, device drives 0x5A
    use_force = 1'b1; f_dout = 8'h5A; f_oe = 1'b1;
    set_req(1, 1'b0, 1'b1, 10'h080, 8'h00);
    repeat (12) one_cycle(1'b0);

    // read with the device not driving: floating-bus value
    f_oe = 1'b0; f_dout = 8'h33;
    set_req(0, 1'b0, 1'b0, 10'h155, 8'h00);
    repeat (12) one_cycle(1'b0);
    use_force = 1'b0;

    // both requesters continuously valid: alternating back-to-back grants
    for (int c = 0; c < 32; c++) begin
      gen(100);
      one_cycle(1'b0);
    end
    repeat (8) one_cycle(1'b0);

    // reset in the middle of an access
    set_req(0, 1'b0, 1'b0, 10'h2AA, 8'h00);
    n = 0;
    while (!(act_m && (k % PER) == 1) && n < 40) begin
      one_cycle(1'b0);
      n++;
    end
    #1;
    chk("mid_busy_cs1", 32'(dev_cs1), 32'd1);
    one_cycle(1'b1);
    set_req(1, 1'b1, 1'b1, 10'h3C3, 8'h7E);
    repeat (30) one_cycle(1'b0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      gen(35);
      one_cycle(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
